// File: rtl/miss_fill_controller_if.sv
// Bundle of miss, memory and arrays-updater signals for the miss fill stage.
// The controller connects through the master modport; its surroundings use the slave modport.
interface miss_fill_controller_if #(
    parameter int MEM_DATA_WIDTH = 320,
    parameter int BEAT_WIDTH     = 64,
    parameter int SET_ADDR_WIDTH = 4,
    parameter int TAG_BITS_WIDTH = 8,
    parameter int MASK_WIDTH     = 4
);
    logic                                     i_halt;
    logic                                     i_miss;
    logic                                     i_miss_valid;
    logic [SET_ADDR_WIDTH-1:0]                i_miss_set_addr;
    logic [TAG_BITS_WIDTH-1:0]                i_miss_tag_bits;
    logic                                     o_mem_req;
    logic [TAG_BITS_WIDTH+SET_ADDR_WIDTH-1:0] o_mem_req_addr;
    logic                                     i_mem_req_ready;
    logic [BEAT_WIDTH-1:0]                    i_mem_beat;
    logic                                     i_mem_beat_valid;
    logic                                     o_initiate_arrays_update;
    logic                                     o_iau_valid;
    logic [SET_ADDR_WIDTH-1:0]                o_set_addr;
    logic                                     o_set_addr_valid;
    logic [TAG_BITS_WIDTH-1:0]                o_tag_bits;
    logic                                     o_tag_bits_valid;
    logic [MASK_WIDTH-1:0]                    o_block_replacement_mask;
    logic                                     o_brm_valid;
    logic [MEM_DATA_WIDTH-1:0]                o_mem_data;
    logic                                     o_mem_data_valid;
    logic                                     i_arrays_updated_complete;
    logic                                     i_auc_valid;
    logic                                     o_ready;

    modport master (
        input  i_halt, i_miss, i_miss_valid, i_miss_set_addr, i_miss_tag_bits,
        input  i_mem_req_ready, i_mem_beat, i_mem_beat_valid,
        input  i_arrays_updated_complete, i_auc_valid,
        output o_mem_req, o_mem_req_addr,
        output o_initiate_arrays_update, o_iau_valid,
        output o_set_addr, o_set_addr_valid, o_tag_bits, o_tag_bits_valid,
        output o_block_replacement_mask, o_brm_valid,
        output o_mem_data, o_mem_data_valid, o_ready
    );

    modport slave (
        output i_halt, i_miss, i_miss_valid, i_miss_set_addr, i_miss_tag_bits,
        output i_mem_req_ready, i_mem_beat, i_mem_beat_valid,
        output i_arrays_updated_complete, i_auc_valid,
        input  o_mem_req, o_mem_req_addr,
        input  o_initiate_arrays_update, o_iau_valid,
        input  o_set_addr, o_set_addr_valid, o_tag_bits, o_tag_bits_valid,
        input  o_block_replacement_mask, o_brm_valid,
        input  o_mem_data, o_mem_data_valid, o_ready
    );
endinterface

// File: rtl/miss_fill_controller.sv
// I-cache miss fill: one block read, beat assembly into a line, round-robin victim choice.
// Define MISS_FILL_PER_SET_RR_EN for per-set replacement pointers instead of one global pointer.
module miss_fill_controller #(
    parameter int MEM_DATA_WIDTH = 320,
    parameter int BEAT_WIDTH     = 64,
    parameter int SET_ADDR_WIDTH = 4,
    parameter int TAG_BITS_WIDTH = 8,
    parameter int MASK_WIDTH     = 4
) (
    input logic                    clk,
    input logic                    arst_n,
    miss_fill_controller_if.master bus
);
    localparam int NUM_BEATS = MEM_DATA_WIDTH / BEAT_WIDTH;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int PTR_W     = (MASK_WIDTH > 1) ? $clog2(MASK_WIDTH) : 1;
    localparam int NUM_SETS  = 1 << SET_ADDR_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {IDLE, REQUEST, COLLECT, UPDATE} state_t;

    state_t                    state;
    state_t                    state_next;
    logic [CNT_W-1:0]          cnt;
    logic [MEM_DATA_WIDTH-1:0] line;
    logic [SET_ADDR_WIDTH-1:0] set_q;
    logic [TAG_BITS_WIDTH-1:0] tag_q;
    logic [PTR_W-1:0]          cur_ptr;
    logic                      accept;
    logic                      req_fire;
    logic                      beat_take;
    logic                      complete;
    logic                      mem_req;
    logic                      in_update;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        req_fire   = 1'b0;
        beat_take  = 1'b0;
        complete   = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_miss && bus.i_miss_valid && !bus.i_halt) begin
                    accept     = 1'b1;
                    state_next = REQUEST;
                end
            end
            REQUEST: begin
                mem_req = !bus.i_halt;
                if (mem_req && bus.i_mem_req_ready) begin
                    req_fire   = 1'b1;
                    state_next = COLLECT;
                end
            end
            // Beats are taken even while halted: memory cannot be back-pressured.
            COLLECT: begin
                if (bus.i_mem_beat_valid) begin
                    beat_take = 1'b1;
                    if (cnt == LAST_BEAT) begin
                        state_next = UPDATE;
                    end
                end
            end
            UPDATE: begin
                if (bus.i_arrays_updated_complete && bus.i_auc_valid && !bus.i_halt) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state <= IDLE;
            cnt   <= '0;
            line  <= '0;
            set_q <= '0;
            tag_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                set_q <= bus.i_miss_set_addr;
                tag_q <= bus.i_miss_tag_bits;
            end
            if (req_fire) begin
                cnt <= '0;
            end else if (beat_take) begin
                for (int b = 0; b < NUM_BEATS; b++) begin
                    if (cnt == CNT_W'(b)) begin
                        line[b*BEAT_WIDTH +: BEAT_WIDTH] <= bus.i_mem_beat;
                    end
                end
                cnt <= (cnt == LAST_BEAT) ? '0 : cnt + 1'b1;
            end
        end
    end

`ifdef MISS_FILL_PER_SET_RR_EN
    logic [PTR_W-1:0] rr_ptr [NUM_SETS];

    assign cur_ptr = rr_ptr[set_q];

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else if (complete) begin
            rr_ptr[set_q] <= rr_ptr[set_q] + 1'b1;
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;

    assign cur_ptr = rr_ptr;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rr_ptr <= '0;
        end else if (complete) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end
`endif

    // Every payload is forced to zero whenever its qualifier is low.
    assign in_update                    = (state == UPDATE);
    assign bus.o_ready                  = (state == IDLE) && !bus.i_halt;
    assign bus.o_mem_req                = mem_req;
    assign bus.o_mem_req_addr           = mem_req ? {tag_q, set_q} : '0;
    assign bus.o_initiate_arrays_update = in_update;
    assign bus.o_iau_valid              = in_update;
    assign bus.o_set_addr               = in_update ? set_q : '0;
    assign bus.o_set_addr_valid         = in_update;
    assign bus.o_tag_bits               = in_update ? tag_q : '0;
    assign bus.o_tag_bits_valid         = in_update;
    assign bus.o_block_replacement_mask = in_update ? (MASK_WIDTH'(1) << cur_ptr) : '0;
    assign bus.o_brm_valid              = in_update;
    assign bus.o_mem_data               = in_update ? line : '0;
    assign bus.o_mem_data_valid         = in_update;
endmodule

// File: tb/tb_miss_fill_controller.sv
// Randomized self-checking bench for miss_fill_controller; victim choice is modelled as
// the count of completed fills (global or per set) modulo the number of ways.
module tb_miss_fill_controller;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int tests_run = 0;
    int tests_failed = 0;
    int fills_global = 0;
    int fills_per_set [16];

    miss_fill_controller_if bus ();

    miss_fill_controller dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] expected_mask(input logic [3:0] set);
`ifdef MISS_FILL_PER_SET_RR_EN
        return 4'(1 << (fills_per_set[set] % 4));
`else
        return 4'(1 << (fills_global % 4));
`endif
    endfunction

    task automatic clear_inputs();
        bus.i_halt = 1'b0;
        bus.i_miss = 1'b0;
        bus.i_miss_valid = 1'b0;
        bus.i_miss_set_addr = '0;
        bus.i_miss_tag_bits = '0;
        bus.i_mem_req_ready = 1'b0;
        bus.i_mem_beat = '0;
        bus.i_mem_beat_valid = 1'b0;
        bus.i_arrays_updated_complete = 1'b0;
        bus.i_auc_valid = 1'b0;
    endtask

    task automatic apply_reset(input int cycles);
        arst_n = 1'b0;
        repeat (cycles) tick();
        arst_n = 1'b1;
        fills_global = 0;
        for (int s = 0; s < 16; s++) fills_per_set[s] = 0;
    endtask

    // One complete miss; noisy adds halts, gaps, stray beats and an ignored miss in UPDATE.
    task automatic run_fill(input logic [3:0] set, input logic [7:0] tag, input int ready_delay,
                            input bit noisy, input bit random_beats, output logic [3:0] seen_mask);
        logic [63:0]  beats [5];
        logic [319:0] exp_line;
        logic [3:0]   exp_mask;
        for (int k = 0; k < 5; k++) begin
            beats[k] = random_beats ? {$urandom(), $urandom()} : 64'h1111_1111_1111_1111 * 64'(k);
            exp_line[k*64 +: 64] = beats[k];
        end
        exp_mask = expected_mask(set);
        clear_inputs();
        #1;
        tests_run++;
        if (bus.o_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL idle_ready: got %b expected 1", bus.o_ready);
        end
        bus.i_miss = 1'b1;
        bus.i_miss_valid = 1'b1;
        bus.i_miss_set_addr = set;
        bus.i_miss_tag_bits = tag;
        bus.i_mem_req_ready = (ready_delay == 0);
        tick();
        bus.i_miss = 1'b0;
        bus.i_miss_valid = 1'b0;
        #1;
        tests_run++;
        if (bus.o_mem_req !== 1'b1 || bus.o_mem_req_addr !== {tag, set} || bus.o_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mem_req: got req=%b addr=%h ready=%b expected req=1 addr=%h ready=0",
                     bus.o_mem_req, bus.o_mem_req_addr, bus.o_ready, {tag, set});
        end
        for (int i = 0; i < ready_delay; i++) begin
            bus.i_halt = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.i_mem_beat_valid = noisy;
            bus.i_mem_beat = {$urandom(), $urandom()};
            #1;
            tests_run++;
            if (bus.o_mem_req !== !bus.i_halt) begin
                tests_failed++;
                $display("[TB] FAIL req_stall: got %b expected %b", bus.o_mem_req, !bus.i_halt);
            end
            tick();
        end
        bus.i_halt = 1'b0;
        bus.i_mem_beat_valid = 1'b0;
        bus.i_mem_req_ready = 1'b1;
        tick();
        bus.i_mem_req_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (noisy) begin
                repeat ($urandom_range(0, 2)) begin
                    bus.i_mem_beat_valid = 1'b0;
                    bus.i_mem_beat = {$urandom(), $urandom()};
                    bus.i_halt = 1'($urandom_range(0, 1));
                    #1;
                    tests_run++;
                    if (bus.o_iau_valid !== 1'b0) begin
                        tests_failed++;
                        $display("[TB] FAIL early_update: got %b expected 0", bus.o_iau_valid);
                    end
                    tick();
                end
            end
            bus.i_mem_beat_valid = 1'b1;
            bus.i_mem_beat = beats[k];
            bus.i_halt = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        bus.i_mem_beat_valid = 1'b0;
        bus.i_halt = 1'b0;
        #1;
        tests_run++;
        if ({bus.o_initiate_arrays_update, bus.o_iau_valid, bus.o_set_addr_valid, bus.o_tag_bits_valid,
             bus.o_brm_valid, bus.o_mem_data_valid, bus.o_ready, bus.o_mem_req} !== 8'b1111_1100) begin
            tests_failed++;
            $display("[TB] FAIL update_valids: got %b expected 11111100",
                     {bus.o_initiate_arrays_update, bus.o_iau_valid, bus.o_set_addr_valid,
                      bus.o_tag_bits_valid, bus.o_brm_valid, bus.o_mem_data_valid, bus.o_ready,
                      bus.o_mem_req});
        end
        tests_run++;
        if (bus.o_mem_data !== exp_line) begin
            tests_failed++;
            $display("[TB] FAIL line_data: got %h expected %h", bus.o_mem_data, exp_line);
        end
        tests_run++;
        if (bus.o_set_addr !== set || bus.o_tag_bits !== tag || bus.o_block_replacement_mask !== exp_mask) begin
            tests_failed++;
            $display("[TB] FAIL update_fields: got set=%h tag=%h mask=%b expected set=%h tag=%h mask=%b",
                     bus.o_set_addr, bus.o_tag_bits, bus.o_block_replacement_mask, set, tag, exp_mask);
        end
        seen_mask = bus.o_block_replacement_mask;
        if (noisy) begin
            bus.i_miss = 1'b1;
            bus.i_miss_valid = 1'b1;
            bus.i_miss_set_addr = ~set;
            tick();
            bus.i_miss = 1'b0;
            bus.i_miss_valid = 1'b0;
            bus.i_halt = 1'b1;
            bus.i_arrays_updated_complete = 1'b1;
            bus.i_auc_valid = 1'b1;
            tick();
            tests_run++;
            if (bus.o_iau_valid !== 1'b1 || bus.o_ready !== 1'b0 || bus.o_mem_data !== exp_line ||
                bus.o_set_addr !== set || bus.o_block_replacement_mask !== exp_mask) begin
                tests_failed++;
                $display("[TB] FAIL update_hold: got iau=%b ready=%b set=%h mask=%b expected iau=1 ready=0 set=%h mask=%b",
                         bus.o_iau_valid, bus.o_ready, bus.o_set_addr, bus.o_block_replacement_mask,
                         set, exp_mask);
            end
        end
        bus.i_halt = 1'b0;
        bus.i_arrays_updated_complete = 1'b1;
        bus.i_auc_valid = 1'b1;
        tick();
        bus.i_arrays_updated_complete = 1'b0;
        bus.i_auc_valid = 1'b0;
        fills_global++;
        fills_per_set[set]++;
        #1;
        tests_run++;
        if (bus.o_iau_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_mem_data !== '0 ||
            bus.o_block_replacement_mask !== 4'b0 || bus.o_set_addr !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL after_complete: got iau=%b ready=%b mask=%b expected iau=0 ready=1 mask=0000",
                     bus.o_iau_valid, bus.o_ready, bus.o_block_replacement_mask);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        apply_reset(3);
        tests_run++;
        if (bus.o_ready !== 1'b1 || bus.o_mem_req !== 1'b0 || bus.o_iau_valid !== 1'b0 ||
            bus.o_mem_data !== '0 || bus.o_block_replacement_mask !== 4'b0 || bus.o_mem_req_addr !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got ready=%b req=%b iau=%b expected ready=1 req=0 iau=0",
                     bus.o_ready, bus.o_mem_req, bus.o_iau_valid);
        end
        bus.i_halt = 1'b1;
        #1;
        tests_run++;
        if (bus.o_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_halt_ready: got %b expected 0", bus.o_ready);
        end
        bus.i_halt = 1'b0;
    endtask

    task automatic test_basic_fill();
        logic [3:0] m;
        run_fill(4'h3, 8'hA5, 0, 1'b0, 1'b0, m);
        tests_run++;
        if (m !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL basic_mask: got %b expected 0001", m);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] m [4];
        logic [3:0] exp [4];
        apply_reset(2);
`ifdef MISS_FILL_PER_SET_RR_EN
        exp = '{4'b0001, 4'b0010, 4'b0100, 4'b0001};
`else
        exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
        for (int i = 0; i < 3; i++) run_fill(4'h3, 8'($urandom()), 0, 1'b0, 1'b1, m[i]);
        run_fill(4'h7, 8'($urandom()), 0, 1'b0, 1'b1, m[3]);
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (m[i] !== exp[i]) begin
                tests_failed++;
                $display("[TB] FAIL rr_mask%0d: got %b expected %b", i, m[i], exp[i]);
            end
        end
    endtask

    task automatic test_stall_and_gaps();
        logic [3:0] m;
        run_fill(4'h9, 8'h3C, 4, 1'b1, 1'b1, m);
        for (int i = 0; i < 6; i++) begin
            run_fill(4'($urandom_range(0, 15)), 8'($urandom()), int'($urandom_range(0, 4)), 1'b1, 1'b1, m);
        end
    endtask

    task automatic test_ignored_inputs();
        logic [3:0] m;
        for (int i = 0; i < 2; i++) begin
            bus.i_arrays_updated_complete = 1'b1;
            bus.i_auc_valid = 1'b1;
            bus.i_mem_beat_valid = 1'b1;
            bus.i_mem_beat = {$urandom(), $urandom()};
            tick();
            tests_run++;
            if (bus.o_ready !== 1'b1 || bus.o_iau_valid !== 1'b0 || bus.o_mem_req !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL idle_spurious: got ready=%b iau=%b req=%b expected ready=1 iau=0 req=0",
                         bus.o_ready, bus.o_iau_valid, bus.o_mem_req);
            end
        end
        clear_inputs();
        run_fill(4'h5, 8'h77, 1, 1'b1, 1'b1, m);
    endtask

    task automatic test_reset_mid_fill();
        logic [3:0] m;
        clear_inputs();
        bus.i_miss = 1'b1;
        bus.i_miss_valid = 1'b1;
        bus.i_miss_set_addr = 4'hC;
        bus.i_miss_tag_bits = 8'h42;
        bus.i_mem_req_ready = 1'b1;
        tick();
        bus.i_miss = 1'b0;
        bus.i_miss_valid = 1'b0;
        tick();
        bus.i_mem_req_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.i_mem_beat_valid = 1'b1;
            bus.i_mem_beat = {$urandom(), $urandom()};
            tick();
        end
        bus.i_mem_beat_valid = 1'b0;
        apply_reset(1);
        tests_run++;
        if (bus.o_ready !== 1'b1 || bus.o_mem_req !== 1'b0 || bus.o_iau_valid !== 1'b0 ||
            bus.o_mem_data !== '0 || bus.o_set_addr !== 4'h0 || bus.o_tag_bits !== 8'h0) begin
            tests_failed++;
            $display("[TB] FAIL mid_fill_reset: got ready=%b req=%b iau=%b expected ready=1 req=0 iau=0",
                     bus.o_ready, bus.o_mem_req, bus.o_iau_valid);
        end
        repeat (3) begin
            tick();
            tests_run++;
            if (bus.o_iau_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL no_partial_update: got %b expected 0", bus.o_iau_valid);
            end
        end
        run_fill(4'hC, 8'h42, 0, 1'b0, 1'b1, m);
        tests_run++;
        if (m !== 4'b0001) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_mask: got %b expected 0001", m);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_basic_fill();
        test_round_robin();
        test_stall_and_gaps();
        test_ignored_inputs();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
